// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the handshaked integer ALU.
// Holds op-mode codes, per-mode function encodings, the control state enum
// and a constant clog2 helper used to size shift amounts and counters.
package alu_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FUNC_W = 3;

    // Operation modes
    localparam logic [OP_W-1:0] OP_IDLE    = 3'd0;
    localparam logic [OP_W-1:0] OP_LOGIC   = 3'd1;
    localparam logic [OP_W-1:0] OP_SHIFT   = 3'd2;
    localparam logic [OP_W-1:0] OP_COMPARE = 3'd3;
    localparam logic [OP_W-1:0] OP_ADD_SUB = 3'd4;
    localparam logic [OP_W-1:0] OP_MUL     = 3'd5;
    localparam logic [OP_W-1:0] OP_DIV     = 3'd6;
    localparam logic [OP_W-1:0] OP_MOD     = 3'd7;

    // LOGIC func[1:0]
    localparam logic [1:0] LOG_AND    = 2'b00;
    localparam logic [1:0] LOG_OR     = 2'b01;
    localparam logic [1:0] LOG_XOR    = 2'b10;
    localparam logic [1:0] LOG_PASS_B = 2'b11;

    // COMPARE func[1:0]; func[CMP_INV_BIT] inverts the outcome
    localparam logic [1:0] CMP_LT  = 2'b00;
    localparam logic [1:0] CMP_GT  = 2'b01;
    localparam logic [1:0] CMP_EQ  = 2'b10;
    localparam logic [1:0] CMP_LTU = 2'b11;
    localparam int unsigned CMP_INV_BIT = 2;

    // MUL func[1:0]
    localparam logic [1:0] MUL_LO  = 2'b00;
    localparam logic [1:0] MUL_HSS = 2'b01;
    localparam logic [1:0] MUL_HSU = 2'b10;
    localparam logic [1:0] MUL_HUU = 2'b11;

    // Single-bit option positions
    localparam int unsigned SHF_DIR_BIT   = 1;  // 1: right
    localparam int unsigned SHF_ARITH_BIT = 0;  // 1: arithmetic (right only)
    localparam int unsigned ADD_SUB_BIT   = 0;  // 1: subtract
    localparam int unsigned DIV_UNS_BIT   = 0;  // 1: unsigned

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Ceiling log2 for elaboration-time sizing
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_hs_if.sv
// alu_hs_if: request/result handshake bundle of the ALU.
// Request side: i_valid/o_ready with i_op_mode, i_func_op, i_a, i_b.
// Result side: o_valid/i_ready with o_result, o_dz; o_busy flags multi-cycle work.
// slave = ALU side, master = requester/consumer side.
interface alu_hs_if
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) ();

    logic              i_valid;
    logic              o_ready;
    logic [OP_W-1:0]   i_op_mode;
    logic [FUNC_W-1:0] i_func_op;
    logic [WIDTH-1:0]  i_a;
    logic [WIDTH-1:0]  i_b;
    logic              o_valid;
    logic              i_ready;
    logic [WIDTH-1:0]  o_result;
    logic              o_dz;
    logic              o_busy;

    modport slave (
        input  i_valid, i_op_mode, i_func_op, i_a, i_b, i_ready,
        output o_ready, o_valid, o_result, o_dz, o_busy
    );

    modport master (
        output i_valid, i_op_mode, i_func_op, i_a, i_b, i_ready,
        input  o_ready, o_valid, o_result, o_dz, o_busy
    );

endinterface

// File: rtl/int_div_seq.sv
// int_div_seq: iterative unsigned restoring divider, one quotient bit per cycle.
// Ports: clk_i, rst_ni (sync, active-low), start_i loads dividend_i/divisor_i;
// done_c_o is high in the cycle whose closing edge performs the final iteration;
// quotient_o/remainder_o are registered and final after that edge.
// Magnitudes only; divisor must be non-zero.
module int_div_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             done_c_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CNT_W = clog2(WIDTH);

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   partial_c;
    logic [WIDTH:0]   diff_c;
    logic             ge_c;

    // Shift next dividend bit into the partial remainder and trial-subtract.
    // partial < 2*divisor, so diff bit WIDTH is a clean borrow flag.
    assign partial_c = {rem_q, quo_q[WIDTH-1]};
    assign diff_c    = partial_c - {1'b0, dvs_q};
    assign ge_c      = ~diff_c[WIDTH];

    assign done_c_o    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= '0;
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
        end else if (busy_q) begin
            quo_q <= {quo_q[WIDTH-2:0], ge_c};
            rem_q <= ge_c ? diff_c[WIDTH-1:0] : partial_c[WIDTH-1:0];
            cnt_q <= cnt_q + 1'b1;
            if (done_c_o) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_hs.sv
// alu_hs: integer ALU with valid/ready handshake on request and result.
// Ports: i_clk, i_rst_n (sync, active-low), bus (alu_hs_if.slave).
// Modes 0-4 complete at the accept edge; MUL takes MUL_LAT cycles;
// DIV/MOD run a WIDTH-step divider plus a sign fix-up cycle, except
// divide-by-zero and signed MIN/-1 which complete at the accept edge.
// One result buffer: o_result/o_dz/o_valid hold until consumed.
module alu_hs
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    alu_hs_if.slave  bus
);

    localparam int unsigned SH_W   = clog2(WIDTH);
    localparam int unsigned MCNT_W = (MUL_LAT > 2) ? clog2(MUL_LAT - 1) : 1;

    state_t              state_q;
    logic                valid_q;
    logic [WIDTH-1:0]    result_q;
    logic                dz_q;
    logic [MCNT_W-1:0]   mul_cnt_q;
    logic [2*WIDTH-1:0]  prod_q;
    logic [1:0]          mfunc_q;
    logic                neg_quo_q;
    logic                neg_rem_q;
    logic                is_mod_q;

    logic                accept_c;
    logic                consume_c;
    logic [WIDTH-1:0]    single_res_c;
    logic                cmp_c;
    logic [SH_W-1:0]     shamt_c;
    logic                mul_a_sx_c;
    logic                mul_b_sx_c;
    logic [2*WIDTH-1:0]  mul_a_c;
    logic [2*WIDTH-1:0]  mul_b_c;
    logic [2*WIDTH-1:0]  mul_full_c;
    logic                div_mode_c;
    logic                div_uns_c;
    logic                a_neg_c;
    logic                b_neg_c;
    logic [WIDTH-1:0]    mag_a_c;
    logic [WIDTH-1:0]    mag_b_c;
    logic                b_zero_c;
    logic                ovf_c;
    logic                div_start_c;
    logic                div_done_c;
    logic [WIDTH-1:0]    div_quo;
    logic [WIDTH-1:0]    div_rem;
    logic [WIDTH-1:0]    fix_res_c;
    logic                load_c;
    logic [WIDTH-1:0]    load_res_c;
    logic                load_dz_c;

    // Low word or high word of the 2*WIDTH product
    function automatic logic [WIDTH-1:0] mul_pick(input logic [2*WIDTH-1:0] p,
                                                  input logic [1:0]         f);
        return (f == MUL_LO) ? p[WIDTH-1:0] : p[2*WIDTH-1:WIDTH];
    endfunction

    assign bus.o_ready  = (state_q == S_IDLE) && (!valid_q || bus.i_ready);
    assign bus.o_valid  = valid_q;
    assign bus.o_result = result_q;
    assign bus.o_dz     = dz_q;
    assign bus.o_busy   = (state_q != S_IDLE);

    assign accept_c  = bus.i_valid && bus.o_ready;
    assign consume_c = valid_q && bus.i_ready;
    assign shamt_c   = bus.i_b[SH_W-1:0];

    // Single-cycle datapath: logic, shift, compare, add/sub
    always_comb begin
        single_res_c = bus.i_a;
        cmp_c        = 1'b0;
        case (bus.i_op_mode)
            OP_LOGIC: begin
                case (bus.i_func_op[1:0])
                    LOG_AND: single_res_c = bus.i_a & bus.i_b;
                    LOG_OR:  single_res_c = bus.i_a | bus.i_b;
                    LOG_XOR: single_res_c = bus.i_a ^ bus.i_b;
                    default: single_res_c = bus.i_b;
                endcase
            end
            OP_SHIFT: begin
                if (!bus.i_func_op[SHF_DIR_BIT]) begin
                    single_res_c = bus.i_a << shamt_c;
                end else if (bus.i_func_op[SHF_ARITH_BIT]) begin
                    single_res_c = $unsigned($signed(bus.i_a) >>> shamt_c);
                end else begin
                    single_res_c = bus.i_a >> shamt_c;
                end
            end
            OP_COMPARE: begin
                case (bus.i_func_op[1:0])
                    CMP_LT:  cmp_c = $signed(bus.i_a) < $signed(bus.i_b);
                    CMP_GT:  cmp_c = $signed(bus.i_a) > $signed(bus.i_b);
                    CMP_EQ:  cmp_c = bus.i_a == bus.i_b;
                    default: cmp_c = bus.i_a < bus.i_b;
                endcase
                cmp_c        = cmp_c ^ bus.i_func_op[CMP_INV_BIT];
                single_res_c = {{(WIDTH-1){1'b0}}, cmp_c};
            end
            OP_ADD_SUB: begin
                single_res_c = bus.i_func_op[ADD_SUB_BIT] ? (bus.i_a - bus.i_b)
                                                          : (bus.i_a + bus.i_b);
            end
            default: single_res_c = bus.i_a;
        endcase
    end

    // One 2*WIDTH multiplier; operand extension selects the signedness
    assign mul_a_sx_c = (bus.i_func_op[1:0] == MUL_HSS || bus.i_func_op[1:0] == MUL_HSU)
                        && bus.i_a[WIDTH-1];
    assign mul_b_sx_c = (bus.i_func_op[1:0] == MUL_HSS) && bus.i_b[WIDTH-1];
    assign mul_a_c    = {{WIDTH{mul_a_sx_c}}, bus.i_a};
    assign mul_b_c    = {{WIDTH{mul_b_sx_c}}, bus.i_b};
    assign mul_full_c = mul_a_c * mul_b_c;

    // Divider front end: magnitudes, result signs and short-circuit cases
    assign div_mode_c  = (bus.i_op_mode == OP_DIV) || (bus.i_op_mode == OP_MOD);
    assign div_uns_c   = bus.i_func_op[DIV_UNS_BIT];
    assign a_neg_c     = !div_uns_c && bus.i_a[WIDTH-1];
    assign b_neg_c     = !div_uns_c && bus.i_b[WIDTH-1];
    assign mag_a_c     = a_neg_c ? -bus.i_a : bus.i_a;
    assign mag_b_c     = b_neg_c ? -bus.i_b : bus.i_b;
    assign b_zero_c    = (bus.i_b == '0);
    assign ovf_c       = !div_uns_c && (bus.i_a == {1'b1, {(WIDTH-1){1'b0}}})
                         && (bus.i_b == '1);
    assign div_start_c = accept_c && (state_q == S_IDLE) && div_mode_c
                         && !b_zero_c && !ovf_c;

    int_div_seq #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk_i       (i_clk),
        .rst_ni      (i_rst_n),
        .start_i     (div_start_c),
        .dividend_i  (mag_a_c),
        .divisor_i   (mag_b_c),
        .done_c_o    (div_done_c),
        .quotient_o  (div_quo),
        .remainder_o (div_rem)
    );

    assign fix_res_c = is_mod_q ? (neg_rem_q ? -div_rem : div_rem)
                                : (neg_quo_q ? -div_quo : div_quo);

    // Result-buffer load selection
    always_comb begin
        load_c     = 1'b0;
        load_res_c = '0;
        load_dz_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (bus.i_op_mode == OP_MUL) begin
                        if (MUL_LAT == 1) begin
                            load_c     = 1'b1;
                            load_res_c = mul_pick(mul_full_c, bus.i_func_op[1:0]);
                        end
                    end else if (div_mode_c) begin
                        if (b_zero_c) begin
                            load_c     = 1'b1;
                            load_res_c = (bus.i_op_mode == OP_DIV) ? '1 : bus.i_a;
                            load_dz_c  = 1'b1;
                        end else if (ovf_c) begin
                            load_c     = 1'b1;
                            load_res_c = (bus.i_op_mode == OP_DIV) ? bus.i_a : '0;
                        end
                    end else begin
                        load_c     = 1'b1;
                        load_res_c = single_res_c;
                    end
                end
            end
            S_MUL: begin
                if (mul_cnt_q == MCNT_W'(MUL_LAT - 2)) begin
                    load_c     = 1'b1;
                    load_res_c = mul_pick(prod_q, mfunc_q);
                end
            end
            S_FIX: begin
                load_c     = 1'b1;
                load_res_c = fix_res_c;
            end
            default: ;
        endcase
    end

    // Control FSM and result buffer
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            result_q  <= '0;
            dz_q      <= 1'b0;
            mul_cnt_q <= '0;
            prod_q    <= '0;
            mfunc_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_mod_q  <= 1'b0;
        end else begin
            if (load_c) begin
                valid_q  <= 1'b1;
                result_q <= load_res_c;
                dz_q     <= load_dz_c;
            end else if (consume_c) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (accept_c && bus.i_op_mode == OP_MUL && MUL_LAT > 1) begin
                        state_q   <= S_MUL;
                        prod_q    <= mul_full_c;
                        mfunc_q   <= bus.i_func_op[1:0];
                        mul_cnt_q <= '0;
                    end else if (div_start_c) begin
                        state_q   <= S_DIV;
                        neg_quo_q <= a_neg_c ^ b_neg_c;
                        neg_rem_q <= a_neg_c;
                        is_mod_q  <= (bus.i_op_mode == OP_MOD);
                    end
                end
                S_MUL: begin
                    if (mul_cnt_q == MCNT_W'(MUL_LAT - 2)) begin
                        state_q <= S_IDLE;
                    end else begin
                        mul_cnt_q <= mul_cnt_q + 1'b1;
                    end
                end
                S_DIV: begin
                    if (div_done_c) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_hs.sv
// tb_alu_hs: directed and randomized checks of alu_hs against an arithmetic
// reference model. Latency is measured as edges from the accept edge to the
// edge that loads the result.
module tb_alu_hs;
    import alu_pkg::*;

    localparam int unsigned W  = 32;
    localparam int unsigned ML = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_hs_if #(.WIDTH(W)) aif ();

    alu_hs #(
        .WIDTH   (W),
        .MUL_LAT (ML)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (aif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: result, dz flag and load latency in edges after accept
    function automatic void ref_model(input logic [2:0] m, input logic [2:0] f,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic dz, output int lat);
        int signed   sa;
        int signed   sb;
        int unsigned sh;
        logic        cmp;
        logic [63:0] pss;
        logic [63:0] psu;
        logic [63:0] puu;
        sa  = a;
        sb  = b;
        sh  = int'(b[4:0]);
        r   = '0;
        dz  = 1'b0;
        lat = 0;
        cmp = 1'b0;
        case (m)
            3'd0: r = a;
            3'd1: begin
                case (f[1:0])
                    2'd0:    r = a & b;
                    2'd1:    r = a | b;
                    2'd2:    r = a ^ b;
                    default: r = b;
                endcase
            end
            3'd2: begin
                if (!f[1])     r = a << sh;
                else if (f[0]) r = $unsigned(sa >>> sh);
                else           r = a >> sh;
            end
            3'd3: begin
                case (f[1:0])
                    2'd0:    cmp = (sa < sb);
                    2'd1:    cmp = (sa > sb);
                    2'd2:    cmp = (a == b);
                    default: cmp = (a < b);
                endcase
                if (f[2]) cmp = !cmp;
                r = {31'b0, cmp};
            end
            3'd4: r = f[0] ? (a - b) : (a + b);
            3'd5: begin
                pss = 64'(longint'(sa) * longint'(sb));
                psu = 64'(longint'(sa) * longint'({32'b0, b}));
                puu = {32'b0, a} * {32'b0, b};
                case (f[1:0])
                    2'd0:    r = puu[31:0];
                    2'd1:    r = pss[63:32];
                    2'd2:    r = psu[63:32];
                    default: r = puu[63:32];
                endcase
                lat = int'(ML) - 1;
            end
            default: begin
                if (b == 32'd0) begin
                    r  = (m == 3'd6) ? 32'hFFFF_FFFF : a;
                    dz = 1'b1;
                end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r = (m == 3'd6) ? a : 32'd0;
                end else begin
                    lat = int'(W) + 1;
                    if (f[0]) r = (m == 3'd6) ? (a / b) : (a % b);
                    else      r = (m == 3'd6) ? $unsigned(sa / sb) : $unsigned(sa % sb);
                end
            end
        endcase
    endfunction

    task automatic drive_req(input logic [2:0] m, input logic [2:0] f,
                             input logic [31:0] a, input logic [31:0] b);
        aif.i_op_mode = m;
        aif.i_func_op = f;
        aif.i_a       = a;
        aif.i_b       = b;
        aif.i_valid   = 1'b1;
    endtask

    // Issue one request at a negedge, wait for its result, check it.
    // Returns at the negedge where o_valid is seen (consumed at the next edge).
    task automatic do_op(input string tag, input logic [2:0] m, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] b, output int busy_n);
        logic [31:0] er;
        logic        edz;
        int          elat;
        int          k;
        ref_model(m, f, a, b, er, edz, elat);
        drive_req(m, f, a, b);
        aif.i_ready = 1'b1;
        k = 0;
        while (!aif.o_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check_eq($sformatf("%s.ready", tag), 64'(aif.o_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        aif.i_valid = 1'b0;
        k      = 1;
        busy_n = 0;
        while (!aif.o_valid && k < 100) begin
            if (aif.o_busy) busy_n++;
            @(negedge clk);
            k++;
        end
        check_eq($sformatf("%s.valid", tag), 64'(aif.o_valid), 64'd1);
        check_eq($sformatf("%s.lat", tag), 64'(k - 1), 64'(elat));
        check_eq($sformatf("%s.res", tag), 64'(aif.o_result), 64'(er));
        check_eq($sformatf("%s.dz", tag), 64'(aif.o_dz), 64'(edz));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int          busy_n;
        logic        seen;
        logic [2:0]  m;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int unsigned sel;

        rst_n         = 1'b0;
        aif.i_valid   = 1'b0;
        aif.i_ready   = 1'b0;
        aif.i_op_mode = '0;
        aif.i_func_op = '0;
        aif.i_a       = '0;
        aif.i_b       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check_eq("rst.valid", 64'(aif.o_valid), 64'd0);
        check_eq("rst.result", 64'(aif.o_result), 64'd0);
        check_eq("rst.dz", 64'(aif.o_dz), 64'd0);
        check_eq("rst.busy", 64'(aif.o_busy), 64'd0);
        check_eq("rst.ready", 64'(aif.o_ready), 64'd1);

        // Back-to-back add then subtract
        drive_req(OP_ADD_SUB, 3'd0, 32'd5, 32'd7);
        aif.i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b.v1", 64'(aif.o_valid), 64'd1);
        check_eq("b2b.r1", 64'(aif.o_result), 64'd12);
        check_eq("b2b.rdy1", 64'(aif.o_ready), 64'd1);
        drive_req(OP_ADD_SUB, 3'd1, 32'd3, 32'd10);
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b.v2", 64'(aif.o_valid), 64'd1);
        check_eq("b2b.r2", 64'(aif.o_result), 64'hFFFF_FFF9);
        check_eq("b2b.rdy2", 64'(aif.o_ready), 64'd1);
        aif.i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b.drain", 64'(aif.o_valid), 64'd0);

        // Output stall holds the result and blocks new requests
        drive_req(OP_LOGIC, 3'd2, 32'h0000_F0F0, 32'h0000_0FF0);
        aif.i_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        drive_req(OP_ADD_SUB, 3'd0, 32'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("stall.res%0d", i), 64'(aif.o_result), 64'h0000_FF00);
            check_eq($sformatf("stall.v%0d", i), 64'(aif.o_valid), 64'd1);
            check_eq($sformatf("stall.rdy%0d", i), 64'(aif.o_ready), 64'd0);
            @(posedge clk);
            @(negedge clk);
        end
        aif.i_ready = 1'b1;
        #1;
        check_eq("stall.release_rdy", 64'(aif.o_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check_eq("stall.next_res", 64'(aif.o_result), 64'd2);
        check_eq("stall.next_v", 64'(aif.o_valid), 64'd1);
        aif.i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("stall.drain", 64'(aif.o_valid), 64'd0);

        // Multiply variants
        do_op("mul_lo", OP_MUL, 3'd0, 32'hFFFF_FFFF, 32'd2, busy_n);
        check_eq("mul_lo.busy", 64'(busy_n), 64'd1);
        do_op("mul_hss", OP_MUL, 3'd1, 32'hFFFF_FFFF, 32'd2, busy_n);
        check_eq("mul_hss.busy", 64'(busy_n), 64'd1);
        do_op("mul_huu", OP_MUL, 3'd3, 32'hFFFF_FFFF, 32'd2, busy_n);
        check_eq("mul_huu.busy", 64'(busy_n), 64'd1);

        // Divide / modulo, including boundaries
        do_op("div_s", OP_DIV, 3'd0, 32'hFFFF_FFF9, 32'd2, busy_n);
        check_eq("div_s.busy", 64'(busy_n), 64'(W + 1));
        do_op("mod_s", OP_MOD, 3'd0, 32'hFFFF_FFF9, 32'd2, busy_n);
        do_op("div_u", OP_DIV, 3'd1, 32'd100, 32'd7, busy_n);
        do_op("div_z", OP_DIV, 3'd0, 32'd9, 32'd0, busy_n);
        do_op("mod_z", OP_MOD, 3'd0, 32'd9, 32'd0, busy_n);
        do_op("div_ovf", OP_DIV, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, busy_n);
        do_op("mod_ovf", OP_MOD, 3'd0, 32'h8000_0000, 32'hFFFF_FFFF, busy_n);

        // Reset in the middle of a divide
        drive_req(OP_DIV, 3'd0, 32'd100, 32'd3);
        @(posedge clk);
        @(negedge clk);
        aif.i_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("abort.valid", 64'(aif.o_valid), 64'd0);
        check_eq("abort.busy", 64'(aif.o_busy), 64'd0);
        check_eq("abort.ready", 64'(aif.o_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (aif.o_valid) seen = 1'b1;
        end
        check_eq("abort.no_result", 64'(seen), 64'd0);
        do_op("after_abort", OP_DIV, 3'd0, 32'd6, 32'd3, busy_n);

        // Randomized operations
        for (int n = 0; n < 250; n++) begin
            m   = 3'($urandom_range(0, 7));
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0)      b = 32'd0;
            else if (sel == 1) b = 32'hFFFF_FFFF;
            else if (sel < 6)  b = 32'($urandom_range(1, 40));
            else               b = $urandom;
            if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
            do_op($sformatf("rnd%0d_m%0d_f%0d", n, m, f), m, f, a, b, busy_n);
        end

        @(posedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
